// File: rtl/rx_unescape_buf.sv
`default_nettype none
// ============================================================================
// Module   : rx_unescape_buf
// Purpose  : Strips escape symbols from a UART-RX stream and buffers the
//            decoded {command, symbol} entries in a first-word-fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module rx_unescape_buf #(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] ESC    = 8'hB1,
    parameter int                DEPTH  = 4
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [DATA_W-1:0]        DATA_REC_I,
    input  logic                     RX_EMPTY_I,
    output logic                     READ_O,
    input  logic                     READ_I,
    output logic                     RX_EMPTY_O,
    output logic                     COMMAND_O,
    output logic [DATA_W-1:0]        DATA_REC_O,
    output logic [$clog2(DEPTH):0]   LEVEL_O,
    output logic                     ESC_PEND_O
);

    localparam int                c_ADDR_W = $clog2(DEPTH);
    localparam int                c_LVL_W  = c_ADDR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL  = c_LVL_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_ESCAPE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_W:0]        r_mem [DEPTH];
    logic [c_ADDR_W-1:0]    r_wr_ptr;
    logic [c_ADDR_W-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0]     r_level;
    logic                   w_accept;
    logic                   w_is_esc;
    logic                   w_push;
    logic                   w_cmd;
    logic                   w_pop;
    logic                   w_empty;
    logic [DATA_W:0]        w_head;

    // Acceptance looks only at the registered level so a same-cycle pop
    // never creates room combinationally.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_cmd       = 1'b0;
        w_is_esc    = (DATA_REC_I == ESC);
        w_accept    = !RST_I && !RX_EMPTY_I && (r_level < c_FULL);
        if (w_accept) begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_is_esc) begin
                        w_state_nxt = ST_ESCAPE;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                ST_ESCAPE: begin
                    w_push      = 1'b1;
                    w_cmd       = !w_is_esc;
                    w_state_nxt = ST_NORMAL;
                end
                default: w_state_nxt = ST_NORMAL;
            endcase
        end
    end

    assign w_empty = (r_level == '0);
    assign w_pop   = READ_I && !w_empty;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state  <= ST_NORMAL;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: outputs are gated by the level.
    always_ff @(posedge CLK_I) begin
        if (!RST_I && w_push) begin
            r_mem[r_wr_ptr] <= {w_cmd, DATA_REC_I};
        end
    end

    assign READ_O     = w_accept;
    assign RX_EMPTY_O = w_empty;
    assign COMMAND_O  = !w_empty && w_head[DATA_W];
    assign DATA_REC_O = w_empty ? '0 : w_head[DATA_W-1:0];
    assign LEVEL_O    = r_level;
    assign ESC_PEND_O = (r_state == ST_ESCAPE);

endmodule
`default_nettype wire

// File: tb/tb_rx_unescape_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_unescape_buf
// Purpose  : Directed self-checking bench for rx_unescape_buf (8- and 16-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_unescape_buf;

    logic        clk;
    logic        rst;
    logic [7:0]  d8_in;
    logic        e8_in;
    logic        rd8;
    logic        ro8;
    logic        em8;
    logic        cmd8;
    logic [7:0]  d8_out;
    logic [2:0]  lvl8;
    logic        pend8;

    logic [15:0] d16_in;
    logic        e16_in;
    logic        rd16;
    logic        ro16;
    logic        em16;
    logic        cmd16;
    logic [15:0] d16_out;
    logic [2:0]  lvl16;
    logic        pend16;

    int checks;
    int errors;
    int n_reads;
    logic last_ro;
    logic [7:0] q[$];

    rx_unescape_buf #(.DATA_W(8), .ESC(8'hB1), .DEPTH(4)) dut8 (
        .CLK_I(clk), .RST_I(rst), .DATA_REC_I(d8_in), .RX_EMPTY_I(e8_in),
        .READ_O(ro8), .READ_I(rd8), .RX_EMPTY_O(em8), .COMMAND_O(cmd8),
        .DATA_REC_O(d8_out), .LEVEL_O(lvl8), .ESC_PEND_O(pend8)
    );

    rx_unescape_buf #(.DATA_W(16), .ESC(16'h00B1), .DEPTH(4)) dut16 (
        .CLK_I(clk), .RST_I(rst), .DATA_REC_I(d16_in), .RX_EMPTY_I(e16_in),
        .READ_O(ro16), .READ_I(rd16), .RX_EMPTY_O(em16), .COMMAND_O(cmd16),
        .DATA_REC_O(d16_out), .LEVEL_O(lvl16), .ESC_PEND_O(pend16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [3:0][7:0] sym;
        logic [2:0]      lvl;
        logic            cmd;
        logic [7:0]      data;
        logic            pend;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_rx();
        if (q.size() > 0) begin
            d8_in = q[0];
            e8_in = 1'b0;
        end else begin
            d8_in = 8'h00;
            e8_in = 1'b1;
        end
    endtask

    // One clock: present the UART-RX head, pop it if the DUT read it.
    task automatic cyc(input logic rd);
        drive_rx();
        rd8 = rd;
        #1;
        last_ro = ro8;
        if (ro8) n_reads++;
        @(posedge clk);
        if (last_ro) void'(q.pop_front());
        @(negedge clk);
        rd8 = 1'b0;
        drive_rx();
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && q.size() > 0; k++) cyc(1'b0);
        chk("drain", q.size(), 0);
    endtask

    task automatic do_reset();
        q.delete();
        q.push_back(8'h55);
        rst = 1'b1;
        cyc(1'b0);
        chk("rst_read_o", last_ro, 1'b0);
        q.delete();
        rst = 1'b0;
        drive_rx();
        #1;
        chk("rst_empty", em8, 1'b1);
        chk("rst_level", lvl8, 3'd0);
        chk("rst_pend", pend8, 1'b0);
        chk("rst_data", {cmd8, d8_out}, 9'h000);
    endtask

    initial begin
        checks = 0; errors = 0; n_reads = 0; last_ro = 1'b0;
        rst = 1'b1; rd8 = 1'b0; d8_in = '0; e8_in = 1'b1;
        rd16 = 1'b0; d16_in = '0; e16_in = 1'b1;

        tbl[0] = '{n:1, sym:{8'h00, 8'h00, 8'h00, 8'h41}, lvl:3'd1, cmd:1'b0, data:8'h41, pend:1'b0};
        tbl[1] = '{n:2, sym:{8'h00, 8'h00, 8'h05, 8'hB1}, lvl:3'd1, cmd:1'b1, data:8'h05, pend:1'b0};
        tbl[2] = '{n:2, sym:{8'h00, 8'h00, 8'hB1, 8'hB1}, lvl:3'd1, cmd:1'b0, data:8'hB1, pend:1'b0};
        tbl[3] = '{n:1, sym:{8'h00, 8'h00, 8'h00, 8'hB1}, lvl:3'd0, cmd:1'b0, data:8'h00, pend:1'b1};
        tbl[4] = '{n:2, sym:{8'h00, 8'h00, 8'hB1, 8'h05}, lvl:3'd1, cmd:1'b0, data:8'h05, pend:1'b1};
        tbl[5] = '{n:4, sym:{8'h07, 8'hB1, 8'hB1, 8'hB1}, lvl:3'd2, cmd:1'b0, data:8'hB1, pend:1'b0};
        tbl[6] = '{n:3, sym:{8'h00, 8'h00, 8'hB1, 8'hB1}, lvl:3'd2, cmd:1'b0, data:8'hB1, pend:1'b0};

        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            do_reset();
            for (int k = 0; k < tbl[i].n; k++) q.push_back(tbl[i].sym[k]);
            drain();
            chk($sformatf("tbl%0d_level", i), lvl8, tbl[i].lvl);
            chk($sformatf("tbl%0d_cmd", i), cmd8, tbl[i].cmd);
            chk($sformatf("tbl%0d_data", i), d8_out, tbl[i].data);
            chk($sformatf("tbl%0d_pend", i), pend8, tbl[i].pend);
        end

        // Two plain symbols, then pop both
        do_reset();
        n_reads = 0;
        q.push_back(8'h41); q.push_back(8'h42);
        drain();
        chk("two_reads", n_reads, 2);
        chk("two_level", lvl8, 3'd2);
        chk("two_head", {cmd8, d8_out}, 9'h041);
        cyc(1'b1);
        chk("two_pop1", {cmd8, d8_out}, 9'h042);
        cyc(1'b1);
        chk("two_empty", em8, 1'b1);
        chk("two_empty_data", {cmd8, d8_out}, 9'h000);
        cyc(1'b1);
        chk("pop_empty_level", lvl8, 3'd0);

        // Escape gap then command entry
        do_reset();
        q.push_back(8'hB1);
        cyc(1'b0);
        chk("esc_gap_pend", pend8, 1'b1);
        chk("esc_gap_level", lvl8, 3'd0);
        cyc(1'b0);
        chk("esc_gap_wait", pend8, 1'b1);
        q.push_back(8'h05);
        cyc(1'b0);
        chk("esc_cmd_entry", {cmd8, d8_out}, 9'h105);
        chk("esc_cmd_level", lvl8, 3'd1);
        chk("esc_cmd_pend", pend8, 1'b0);

        // B1 B1 B1 07: second entry must be a command
        do_reset();
        q.push_back(8'hB1); q.push_back(8'hB1); q.push_back(8'hB1); q.push_back(8'h07);
        drain();
        cyc(1'b1);
        chk("esc3_second", {cmd8, d8_out}, 9'h107);

        // Fill to full with six symbols
        do_reset();
        n_reads = 0;
        for (int k = 0; k < 6; k++) q.push_back(8'h10 + 8'(k));
        for (int k = 0; k < 6; k++) cyc(1'b0);
        chk("full_reads", n_reads, 4);
        chk("full_level", lvl8, 3'd4);
        chk("full_left", q.size(), 2);
        cyc(1'b1);
        chk("full_pop_read_o", last_ro, 1'b0);
        chk("full_pop_level", lvl8, 3'd3);
        chk("full_pop_head", d8_out, 8'h11);
        cyc(1'b0);
        chk("full_resume", last_ro, 1'b1);
        chk("full_resume_level", lvl8, 3'd4);

        // Simultaneous push and pop at level 2
        do_reset();
        q.push_back(8'h20); q.push_back(8'h21);
        drain();
        q.push_back(8'h22);
        cyc(1'b1);
        chk("pp_read_o", last_ro, 1'b1);
        chk("pp_level", lvl8, 3'd2);
        chk("pp_head", d8_out, 8'h21);

        // Reset discards a pending escape
        do_reset();
        q.push_back(8'hB1);
        cyc(1'b0);
        chk("rst_esc_pre", pend8, 1'b1);
        do_reset();
        q.push_back(8'h05);
        drain();
        chk("rst_esc_entry", {cmd8, d8_out}, 9'h005);
        chk("rst_esc_level", lvl8, 3'd1);

        // 16-bit instance
        do_reset();
        d16_in = 16'h00B1; e16_in = 1'b0;
        #1;
        chk("w16_read1", ro16, 1'b1);
        @(posedge clk); @(negedge clk);
        chk("w16_pend", pend16, 1'b1);
        d16_in = 16'h1234;
        @(posedge clk); @(negedge clk);
        e16_in = 1'b1;
        #1;
        chk("w16_level", lvl16, 3'd1);
        chk("w16_entry", {cmd16, d16_out}, {1'b1, 16'h1234});
        d16_in = 16'h00B1; e16_in = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        e16_in = 1'b1;
        rd16 = 1'b1;
        @(posedge clk); @(negedge clk);
        rd16 = 1'b0;
        #1;
        chk("w16_literal", {cmd16, d16_out}, {1'b0, 16'h00B1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
